// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit with HI/LO registers and fixed-latency Busy
// Optional MDU_MADD_EN enables madd/maddu/msub/msubu (ops 9..12).
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  XALUOp,
    input  logic [31:0] XALUa,
    input  logic [31:0] XALUb,
    output logic [31:0] XALU_Out,
    output logic        Busy,
    output logic        Start
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [63:0]   pend_q, pend_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        is_mul, is_div, is_acc, is_sub, op_signed;
    logic [63:0] ext_a, ext_b, prod, acc;
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b, q_mag, r_mag, quot, rem;

    always_comb begin
        is_mul    = (XALUOp == 4'd1) || (XALUOp == 4'd2);
        is_div    = (XALUOp == 4'd3) || (XALUOp == 4'd4);
`ifdef MDU_MADD_EN
        is_acc    = (XALUOp >= 4'd9) && (XALUOp <= 4'd12);
`else
        is_acc    = 1'b0;
`endif
        is_sub    = (XALUOp == 4'd11) || (XALUOp == 4'd12);
        op_signed = (XALUOp == 4'd1) || (XALUOp == 4'd3) ||
                    (XALUOp == 4'd9) || (XALUOp == 4'd11);
        Start     = !busy_q && (is_mul || is_div || is_acc);
    end

    // Low 64 bits of the product of extended operands is the exact two's-complement result.
    always_comb begin
        ext_a = {(op_signed ? {32{XALUa[31]}} : 32'h0), XALUa};
        ext_b = {(op_signed ? {32{XALUb[31]}} : 32'h0), XALUb};
        prod  = ext_a * ext_b;
        acc   = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
    end

    // Signed divide on magnitudes; the 0x80000000 / -1 case falls out naturally.
    always_comb begin
        a_neg = op_signed && XALUa[31];
        b_neg = op_signed && XALUb[31];
        mag_a = a_neg ? (~XALUa + 32'd1) : XALUa;
        mag_b = b_neg ? (~XALUb + 32'd1) : XALUb;
        if (mag_b == 32'h0) begin
            q_mag = 32'h0;
            r_mag = 32'h0;
        end else begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        wr_d   = wr_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        if (busy_q) begin
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (wr_q) begin
                    hi_d = pend_q[63:32];
                    lo_d = pend_q[31:0];
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (Start) begin
            busy_d = 1'b1;
            cnt_d  = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            pend_d = is_div ? {rem, quot} : (is_acc ? acc : prod);
            wr_d   = !(is_div && (XALUb == 32'h0));
        end else if (XALUOp == 4'd7) begin
            hi_d = XALUa;
        end else if (XALUOp == 4'd8) begin
            lo_d = XALUa;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= '0;
            wr_q   <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
            wr_q   <= wr_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        XALU_Out = 32'h0;
        if (XALUOp == 4'd5)      XALU_Out = hi_q;
        else if (XALUOp == 4'd6) XALU_Out = lo_q;
    end

    assign Busy = busy_q;
endmodule
